spi_master_ctrl: RTL and testbench

- Byte-oriented SPI master controller. Sequences chip-select, serial clock and shift timing for up to NUM_CS SPI slaves on one shared bus.
- The CPU-side bus bridge pushes bytes through a valid/ready handshake. Received bytes return as single-cycle strobes.
- Keeps ncs asserted across multi-byte bursts until a byte tagged as last completes.

---
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_master_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: byte handshake between a CPU-side bus bridge and the
// SPI master controller.
//   xfer_valid / xfer_ready : byte offered / controller can take it
//   xfer_data               : byte to transmit, MSB first
//   xfer_last               : release chip-select after this byte
//   rx_valid / rx_data      : one-cycle strobe with the byte just received
// Modports: master = bus bridge side, slave = controller side.
interface spi_master_ctrl_if;
  logic       xfer_valid;
  logic       xfer_ready;
  logic [7:0] xfer_data;
  logic       xfer_last;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output xfer_valid, xfer_data, xfer_last,
    input  xfer_ready, rx_valid, rx_data
  );

  modport slave (
    input  xfer_valid, xfer_data, xfer_last,
    output xfer_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: byte-oriented SPI master (mode 0, sclk idles low) for up
// to NUM_CS slaves on one shared bus. Chip-select stays asserted across a
// burst until a byte tagged last has completed.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   cfg_div      : half-period select, H = cfg_div+1 clk cycles per phase
//   cfg_cs_sel   : slave index, sampled only when a burst starts
//   bus          : byte handshake (xfer_* in, xfer_ready/rx_* out)
//   busy         : controller not idle
//   spi_sclk/spi_ncs/spi_mosi/spi_miso : SPI pins
// Optional build macro SPI_MASTER_LOOPBACK_EN adds cfg_loopback: when the
// value latched at burst start is 1, the receiver samples spi_mosi instead
// of spi_miso and every spi_ncs stays high.
module spi_master_ctrl #(
  parameter int NUM_CS    = 4,
  parameter int CS_BITS   = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [CS_BITS-1:0]   cfg_cs_sel,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                 cfg_loopback,
`endif
  spi_master_ctrl_if.slave     bus,
  output logic                 busy,
  output logic                 spi_sclk,
  output logic [NUM_CS-1:0]    spi_ncs,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    SHIFT_HI   = 3'd2,
    SHIFT_LO   = 3'd3,
    BURST_WAIT = 3'd4,
    DESELECT   = 3'd5
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1'b1);
  localparam logic [NUM_CS-1:0]    NCS_IDLE = {NUM_CS{1'b1}};

  // Active-low one-hot select; an out-of-range index or loopback selects nobody.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_BITS-1:0] cs,
                                                  input logic lb);
    logic [NUM_CS-1:0] r;
    r = NCS_IDLE;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!lb && (cs == CS_BITS'(i))) r[i] = 1'b0;
    end
    return r;
  endfunction

  state_t               state_r, state_nxt;
  logic [DIV_WIDTH-1:0] cnt_r, cnt_nxt;
  logic [DIV_WIDTH-1:0] div_r, div_nxt;
  logic [CS_BITS-1:0]   cs_r, cs_nxt;
  logic                 last_r, last_nxt;
  logic                 lb_r, lb_nxt;
  logic                 desel_hi_r, desel_hi_nxt;
  logic [3:0]           hi_cnt_r, hi_cnt_nxt;
  logic [7:0]           tx_r, tx_nxt;
  logic [7:0]           rx_sh_r, rx_sh_nxt;
  logic                 sclk_r, sclk_nxt;
  logic                 mosi_r, mosi_nxt;
  logic [NUM_CS-1:0]    ncs_r, ncs_nxt;
  logic                 ready_r, ready_nxt;
  logic                 rx_valid_r, rx_valid_nxt;
  logic [7:0]           rx_data_r, rx_data_nxt;
  logic                 busy_r, busy_nxt;

  logic lb_in_s;
  logic phase_done_s;
  logic accept_s;
  logic sample_s;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_in_s = cfg_loopback;
`else
  assign lb_in_s = 1'b0;
`endif

  assign phase_done_s = (cnt_r == CNT_ZERO);
  assign accept_s     = bus.xfer_valid & ready_r;
  assign sample_s     = lb_r ? mosi_r : spi_miso;

  assign bus.xfer_ready = ready_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.rx_data    = rx_data_r;
  assign busy           = busy_r;
  assign spi_sclk       = sclk_r;
  assign spi_ncs        = ncs_r;
  assign spi_mosi       = mosi_r;

  // Next-state and next-output logic; every phase lasts cnt = div..0.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    div_nxt      = div_r;
    cs_nxt       = cs_r;
    last_nxt     = last_r;
    lb_nxt       = lb_r;
    desel_hi_nxt = desel_hi_r;
    hi_cnt_nxt   = hi_cnt_r;
    tx_nxt       = tx_r;
    rx_sh_nxt    = rx_sh_r;
    mosi_nxt     = mosi_r;
    rx_valid_nxt = 1'b0;
    rx_data_nxt  = rx_data_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt  = SETUP;
          tx_nxt     = bus.xfer_data;
          mosi_nxt   = bus.xfer_data[7];
          last_nxt   = bus.xfer_last;
          div_nxt    = cfg_div;
          cnt_nxt    = cfg_div;
          cs_nxt     = cfg_cs_sel;
          lb_nxt     = lb_in_s;
          hi_cnt_nxt = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (phase_done_s) begin
          state_nxt  = SHIFT_HI;
          cnt_nxt    = div_r;
          rx_sh_nxt  = {rx_sh_r[6:0], sample_s};
          hi_cnt_nxt = hi_cnt_r + 4'd1;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      SHIFT_HI: begin
        if (phase_done_s) begin
          state_nxt = SHIFT_LO;
          cnt_nxt   = div_r;
          // After the 8th high phase a final low phase holds bit0 so the
          // slave keeps hold time before the byte is declared done.
          if (hi_cnt_r != 4'd8) begin
            tx_nxt   = {tx_r[6:0], 1'b0};
            mosi_nxt = tx_r[6];
          end else begin
            mosi_nxt = mosi_r;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      SHIFT_LO: begin
        if (phase_done_s) begin
          cnt_nxt = div_r;
          if (hi_cnt_r == 4'd8) begin
            rx_valid_nxt = 1'b1;
            rx_data_nxt  = rx_sh_r;
            desel_hi_nxt = 1'b0;
            state_nxt    = last_r ? DESELECT : BURST_WAIT;
          end else begin
            state_nxt  = SHIFT_HI;
            rx_sh_nxt  = {rx_sh_r[6:0], sample_s};
            hi_cnt_nxt = hi_cnt_r + 4'd1;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      BURST_WAIT: begin
        // Divider, select and loopback stay as latched at burst start.
        if (accept_s) begin
          state_nxt  = SETUP;
          tx_nxt     = bus.xfer_data;
          mosi_nxt   = bus.xfer_data[7];
          last_nxt   = bus.xfer_last;
          cnt_nxt    = div_r;
          hi_cnt_nxt = 4'd0;
        end else begin
          state_nxt = BURST_WAIT;
        end
      end
      DESELECT: begin
        // First phase keeps ncs low, second guarantees H cycles of ncs high.
        if (phase_done_s) begin
          cnt_nxt = div_r;
          if (desel_hi_r) begin
            state_nxt = IDLE;
          end else begin
            desel_hi_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    sclk_nxt  = (state_nxt == SHIFT_HI);
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE) || (state_nxt == BURST_WAIT);
    if ((state_nxt == IDLE) || ((state_nxt == DESELECT) && desel_hi_nxt)) begin
      ncs_nxt = NCS_IDLE;
    end else begin
      ncs_nxt = cs_decode(cs_nxt, lb_nxt);
    end
  end

  // State, datapath and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      div_r      <= CNT_ZERO;
      cs_r       <= {CS_BITS{1'b0}};
      last_r     <= 1'b0;
      lb_r       <= 1'b0;
      desel_hi_r <= 1'b0;
      hi_cnt_r   <= 4'd0;
      tx_r       <= 8'h00;
      rx_sh_r    <= 8'h00;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      ncs_r      <= NCS_IDLE;
      ready_r    <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      div_r      <= div_nxt;
      cs_r       <= cs_nxt;
      last_r     <= last_nxt;
      lb_r       <= lb_nxt;
      desel_hi_r <= desel_hi_nxt;
      hi_cnt_r   <= hi_cnt_nxt;
      tx_r       <= tx_nxt;
      rx_sh_r    <= rx_sh_nxt;
      sclk_r     <= sclk_nxt;
      mosi_r     <= mosi_nxt;
      ncs_r      <= ncs_nxt;
      ready_r    <= ready_nxt;
      rx_valid_r <= rx_valid_nxt;
      rx_data_r  <= rx_data_nxt;
      busy_r     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a behavioural mode-0 SPI slave,
// sclk phase-width and ncs-gap monitors, and expected values computed from
// the protocol rules (latency 17H+1, select decode, slave-returned data).
module tb_spi_master_ctrl;
  localparam int NUM_CS    = 4;
  localparam int CS_BITS   = 2;
  localparam int DIV_WIDTH = 8;
  localparam logic [NUM_CS-1:0] ALL_HI = {NUM_CS{1'b1}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [CS_BITS-1:0]   cfg_cs_sel;
  logic                 cfg_loopback;
  logic                 busy, spi_sclk, spi_mosi, spi_miso;
  logic [NUM_CS-1:0]    spi_ncs;

  int n_cmp = 0;
  int n_bad = 0;

  spi_master_ctrl_if bus();

  spi_master_ctrl #(.NUM_CS(NUM_CS), .CS_BITS(CS_BITS), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_div(cfg_div),
    .cfg_cs_sel(cfg_cs_sel),
`ifdef SPI_MASTER_LOOPBACK_EN
    .cfg_loopback(cfg_loopback),
`endif
    .bus(bus),
    .busy(busy),
    .spi_sclk(spi_sclk),
    .spi_ncs(spi_ncs),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Behavioural SPI slave: captures mosi on sclk rise, shifts miso on fall.
  logic [7:0] s_resp;
  logic [7:0] s_rx;
  int         s_rises;
  always @(posedge spi_sclk) begin
    s_rx = {s_rx[6:0], spi_mosi};
    s_rises++;
  end
  always @(negedge spi_sclk) begin
    if (s_rises >= 1 && s_rises < 8) spi_miso = s_resp[7 - s_rises];
  end

  // sclk run-length monitor.
  int   mon_h, mon_run, mon_hi_runs, mon_hi_bad, mon_lo_runs, mon_lo_bad;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (spi_sclk !== mon_prev) begin
      if (mon_prev === 1'b1) begin
        mon_hi_runs++;
        if (mon_run != mon_h) mon_hi_bad++;
      end else if (mon_hi_runs > 0) begin
        mon_lo_runs++;
        if (mon_run != mon_h) mon_lo_bad++;
      end
      mon_run  = 1;
      mon_prev = spi_sclk;
    end else begin
      mon_run++;
    end
  end

  // ncs all-high gap monitor between select periods.
  int g_run = 0, g_last = 0;
  bit g_low_seen = 1'b0;
  always @(negedge clk) begin
    if (spi_ncs === ALL_HI) begin
      g_run++;
    end else begin
      if (g_low_seen && g_run > 0) g_last = g_run;
      g_run      = 0;
      g_low_seen = 1'b1;
    end
  end

  function automatic int exp_lat(input int div);
    return 17 * (div + 1) + 1;
  endfunction

  function automatic logic [NUM_CS-1:0] exp_sel(input int cs);
    logic [NUM_CS-1:0] r;
    r = ALL_HI;
    if (cs < NUM_CS) r[cs] = 1'b0;
    return r;
  endfunction

  task automatic prep_slave(input logic [7:0] r);
    s_resp   = r;
    s_rises  = 0;
    s_rx     = 8'h00;
    spi_miso = r[7];
  endtask

  task automatic clear_mon(input int h);
    mon_h = h; mon_hi_runs = 0; mon_hi_bad = 0; mon_lo_runs = 0; mon_lo_bad = 0;
  endtask

  // Offers one byte at the next ready, then counts cycles to rx_valid while
  // tallying cycles whose ncs differs from exp_ncs. Called at a negedge.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic [NUM_CS-1:0] exp_ncs,
                           output int lat, output logic [7:0] rxd, output int ncs_err, output bit tmo);
    int n;
    n = 0; tmo = 1'b0; ncs_err = 0;
    while (bus.xfer_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (bus.xfer_ready !== 1'b1) tmo = 1'b1;
    bus.xfer_valid = 1'b1; bus.xfer_data = d; bus.xfer_last = last;
    @(negedge clk);
    bus.xfer_valid = 1'b0;
    lat = 1;
    while (bus.rx_valid !== 1'b1 && lat < 20000) begin
      if (spi_ncs !== exp_ncs) ncs_err++;
      @(negedge clk);
      lat++;
    end
    if (bus.rx_valid !== 1'b1) tmo = 1'b1;
    rxd = bus.rx_data;
  endtask

  task automatic test_reset();
    int n, pulses;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (spi_ncs !== ALL_HI) begin n_bad++; $display("FAIL reset_ncs: got %b want %b", spi_ncs, ALL_HI); end
    n_cmp++; if (spi_sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
    n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    n_cmp++; if (bus.xfer_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.xfer_ready); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.xfer_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", bus.xfer_ready); end

    // Abort a transfer after three bits.
    cfg_div = 8'd1; cfg_cs_sel = 2'd1;
    prep_slave(8'h5A);
    bus.xfer_valid = 1'b1; bus.xfer_data = 8'hC3; bus.xfer_last = 1'b1;
    @(negedge clk);
    bus.xfer_valid = 1'b0;
    n = 0;
    while (s_rises < 3 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (s_rises < 3) begin n_bad++; $display("FAIL rst_mid_wait: got %0d rises want 3", s_rises); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (spi_ncs !== ALL_HI) begin n_bad++; $display("FAIL rst_mid_ncs: got %b want %b", spi_ncs, ALL_HI); end
    n_cmp++; if (spi_sclk !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sclk: got %b want 0", spi_sclk); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (100) begin @(negedge clk); if (bus.rx_valid === 1'b1) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rst_mid_rx_valid: got %0d pulses want 0", pulses); end
    n_cmp++; if (bus.xfer_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got ready=%b busy=%b want ready=1 busy=0", bus.xfer_ready, busy); end
  endtask

  task automatic test_div0();
    int lat, ne; logic [7:0] rxd; bit tmo;
    cfg_div = 8'd0; cfg_cs_sel = 2'd2;
    prep_slave(8'hA5);
    send_byte(8'h3C, 1'b1, 4'b1011, lat, rxd, ne, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL div0_timeout: got timeout want none"); end
    n_cmp++; if (lat != 18) begin n_bad++; $display("FAIL div0_latency: got %0d want 18", lat); end
    n_cmp++; if (rxd !== 8'hA5) begin n_bad++; $display("FAIL div0_rx_data: got %h want a5", rxd); end
    n_cmp++; if (s_rx !== 8'h3C) begin n_bad++; $display("FAIL div0_slave_rx: got %h want 3c", s_rx); end
    n_cmp++; if (ne != 0) begin n_bad++; $display("FAIL div0_ncs: got %0d bad cycles want 0", ne); end
    @(negedge clk);
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL div0_strobe_width: got %b want 0", bus.rx_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if (spi_ncs !== ALL_HI || busy !== 1'b0) begin n_bad++; $display("FAIL div0_after: got ncs=%b busy=%b want 1111/0", spi_ncs, busy); end
  endtask

  task automatic test_div3();
    int lat, ne, cs; logic [7:0] rxd, d, r; bit tmo;
    cs = $urandom_range(0, NUM_CS - 1);
    d = 8'($urandom); r = 8'($urandom);
    cfg_div = 8'd3; cfg_cs_sel = CS_BITS'(cs);
    clear_mon(4);
    prep_slave(r);
    send_byte(d, 1'b1, exp_sel(cs), lat, rxd, ne, tmo);
    n_cmp++; if (tmo || lat != 69) begin n_bad++; $display("FAIL div3_latency: got %0d (tmo %0d) want 69", lat, tmo); end
    n_cmp++; if (rxd !== r) begin n_bad++; $display("FAIL div3_rx_data: got %h want %h", rxd, r); end
    n_cmp++; if (mon_hi_runs != 8 || mon_hi_bad != 0) begin n_bad++; $display("FAIL div3_high_phases: got %0d runs %0d bad want 8 runs 0 bad", mon_hi_runs, mon_hi_bad); end
    n_cmp++; if (mon_lo_runs != 7 || mon_lo_bad != 0) begin n_bad++; $display("FAIL div3_low_phases: got %0d runs %0d bad want 7 runs 0 bad", mon_lo_runs, mon_lo_bad); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_burst();
    int lat, ne, bad, low; logic [7:0] rxd, r; bit tmo;
    cfg_div = 8'd1; cfg_cs_sel = 2'd0;
    r = 8'($urandom); prep_slave(r);
    send_byte(8'h01, 1'b0, 4'b1110, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || lat != exp_lat(1) || rxd !== r || ne != 0) begin n_bad++; $display("FAIL burst_b1: got lat=%0d rx=%h ncs_err=%0d want lat=%0d rx=%h ncs_err=0", lat, rxd, ne, exp_lat(1), r); end
    cfg_div = 8'd5;
    bad = 0;
    repeat (10) begin @(negedge clk); if (spi_ncs[0] !== 1'b0 || bus.xfer_ready !== 1'b1 || busy !== 1'b1) bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL burst_gap_hold: got %0d bad cycles want 0", bad); end
    r = 8'($urandom); prep_slave(r);
    send_byte(8'h02, 1'b0, 4'b1110, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || lat != exp_lat(1) || rxd !== r || ne != 0) begin n_bad++; $display("FAIL burst_b2: got lat=%0d rx=%h ncs_err=%0d want lat=%0d rx=%h ncs_err=0", lat, rxd, ne, exp_lat(1), r); end
    r = 8'($urandom); prep_slave(r);
    send_byte(8'h03, 1'b1, 4'b1110, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || lat != exp_lat(1) || rxd !== r || ne != 0) begin n_bad++; $display("FAIL burst_b3: got lat=%0d rx=%h ncs_err=%0d want lat=%0d rx=%h ncs_err=0", lat, rxd, ne, exp_lat(1), r); end
    n_cmp++; if (s_rx !== 8'h03) begin n_bad++; $display("FAIL burst_slave_rx: got %h want 03", s_rx); end
    low = 0;
    while (spi_ncs[0] === 1'b0 && low < 100) begin low++; @(negedge clk); end
    n_cmp++; if (low != 2) begin n_bad++; $display("FAIL burst_deselect_hold: got %0d want 2", low); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, ne; logic [7:0] rxd, r, d; bit tmo;
    cfg_div = 8'd1; cfg_cs_sel = 2'd0;
    r = 8'($urandom); prep_slave(r);
    send_byte(8'($urandom), 1'b0, 4'b1110, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || rxd !== r || ne != 0) begin n_bad++; $display("FAIL b2b_a1: got rx=%h ncs_err=%0d want rx=%h ncs_err=0", rxd, ne, r); end
    cfg_cs_sel = 2'd1;
    r = 8'($urandom); prep_slave(r);
    send_byte(8'($urandom), 1'b1, 4'b1110, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || rxd !== r || ne != 0) begin n_bad++; $display("FAIL b2b_a2_cs_ignored: got rx=%h ncs_err=%0d want rx=%h ncs_err=0", rxd, ne, r); end
    g_last = 0;
    r = 8'($urandom); d = 8'($urandom); prep_slave(r);
    send_byte(d, 1'b1, 4'b1101, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || rxd !== r || s_rx !== d || ne != 0) begin n_bad++; $display("FAIL b2b_b1: got rx=%h srx=%h ncs_err=%0d want rx=%h srx=%h ncs_err=0", rxd, s_rx, ne, r, d); end
    n_cmp++; if (g_last < 2) begin n_bad++; $display("FAIL b2b_ncs_gap: got %0d want >=2", g_last); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, ne, cs, div; logic [7:0] rxd, r, d; bit tmo;
    for (int it = 0; it < 10; it++) begin
      d = 8'($urandom); r = 8'($urandom);
      div = $urandom_range(0, 2); cs = $urandom_range(0, NUM_CS - 1);
      cfg_div = DIV_WIDTH'(div); cfg_cs_sel = CS_BITS'(cs);
      prep_slave(r);
      send_byte(d, 1'b1, exp_sel(cs), lat, rxd, ne, tmo);
      n_cmp++; if (tmo || lat != exp_lat(div)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat(div)); end
      n_cmp++; if (rxd !== r || s_rx !== d) begin n_bad++; $display("FAIL rand_data[%0d]: got rx=%h srx=%h want rx=%h srx=%h", it, rxd, s_rx, r, d); end
      n_cmp++; if (ne != 0) begin n_bad++; $display("FAIL rand_ncs[%0d]: got %0d bad cycles want 0", it, ne); end
    end
    repeat (10) @(negedge clk);
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    int lat, ne; logic [7:0] rxd; bit tmo;
    cfg_div = 8'd1; cfg_cs_sel = 2'd0; cfg_loopback = 1'b1;
    prep_slave(8'h69);
    send_byte(8'h96, 1'b1, ALL_HI, lat, rxd, ne, tmo);
    n_cmp++; if (tmo || rxd !== 8'h96) begin n_bad++; $display("FAIL loopback_rx: got %h want 96", rxd); end
    n_cmp++; if (ne != 0) begin n_bad++; $display("FAIL loopback_ncs: got %0d bad cycles want 0", ne); end
    repeat (8) @(negedge clk);
    cfg_loopback = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_div = 8'd0; cfg_cs_sel = 2'd0; cfg_loopback = 1'b0;
    bus.xfer_valid = 1'b0; bus.xfer_data = 8'h00; bus.xfer_last = 1'b0;
    spi_miso = 1'b0; s_rises = 0; s_rx = 8'h00; s_resp = 8'h00;
    clear_mon(1); mon_run = 0;
    test_reset();
    test_div0();
    test_div3();
    test_burst();
    test_back_to_back();
    test_random();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
